// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed byte stream, writes the program
// bytes into a 16-entry RAM at addresses 0..N-1 and holds the CPU in clear
// until the final write has completed.
// Optional feature: define CHECKSUM_EN to require a trailing checksum byte
// (8-bit sum of the program bytes); a mismatch aborts into ERR.
`timescale 1ns/1ps

module program_loader (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       start,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       ram_we,
  output logic       cpu_clr,
  output logic       done,
  output logic       err
);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;
`endif

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;       // next RAM address to write
  logic [3:0] r_last;      // N-1, address of the final program byte
  logic [3:0] r_ram_addr;
  logic [7:0] r_ram_data;
  logic       r_ram_we;
  logic       r_cpu_clr;
  logic       w_accept;
  logic [4:0] w_len;
  logic       w_len_ok;
  logic       w_last_byte;
`ifdef CHECKSUM_EN
  logic [7:0] r_sum;
`endif

  // The loader takes bytes only while a load is in progress or pending.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD: in_ready = 1'b1;
`ifdef CHECKSUM_EN
      S_CHECK:        in_ready = 1'b1;
`endif
      default:        in_ready = 1'b0;
    endcase
  end

  assign w_accept    = in_valid & in_ready;
  assign w_len       = in_data[4:0];
  assign w_len_ok    = (w_len != 5'd0) && (w_len <= 5'd16);
  assign w_last_byte = (r_cnt == r_last);

  // Next-state decode for the load sequence.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_len_ok ? S_LOAD : S_ERR;
      end
      S_LOAD: begin
        if (w_accept && w_last_byte) begin
`ifdef CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef CHECKSUM_EN
      S_CHECK: begin
        if (w_accept) w_next = (in_data == r_sum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (start) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register; clr overrides any handshake or start on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Address counter and registered RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the write port and counter are reset explicitly because a load
    // abandoned by clr must not leave a pending strobe or a stale address.
    if (clr) begin
      r_cnt      <= 4'd0;
      r_last     <= 4'd0;
      r_ram_addr <= 4'd0;
      r_ram_data <= 8'd0;
      r_ram_we   <= 1'b0;
    end else begin
      r_ram_we <= 1'b0;
      if (w_accept && r_state == S_IDLE) begin
        r_cnt  <= 4'd0;
        r_last <= w_len[3:0] - 4'd1;  // N=16 encodes as 0, minus 1 gives 15
      end else if (w_accept && r_state == S_LOAD) begin
        r_ram_addr <= r_cnt;
        r_ram_data <= in_data;
        r_ram_we   <= 1'b1;
        r_cnt      <= r_cnt + 4'd1;
      end
    end
  end

`ifdef CHECKSUM_EN
  // Running mod-256 sum of the program bytes, restarted by each length byte.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sum <= 8'd0;
    end else if (w_accept && r_state == S_IDLE) begin
      r_sum <= 8'd0;
    end else if (w_accept && r_state == S_LOAD) begin
      r_sum <= r_sum + in_data;
    end
  end
`endif

  // CPU clear: released one edge after DONE is entered (after the last write
  // strobe), re-asserted on the same edge that start leaves DONE.
  always_ff @(posedge clk) begin
    if (clr) r_cpu_clr <= 1'b1;
    else     r_cpu_clr <= !((r_state == S_DONE) && (w_next == S_DONE));
  end

  assign ram_addr = r_ram_addr;
  assign ram_data = r_ram_data;
  assign ram_we   = r_ram_we;
  assign cpu_clr  = r_cpu_clr;
  assign done     = ~r_cpu_clr;
  assign err      = (r_state == S_ERR);

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized streams for program_loader,
// checked against a stream-level model (length rule, expected write list,
// mod-256 checksum outcome). Honours CHECKSUM_EN like the design.
`timescale 1ns/1ps

module tb_program_loader;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       start;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       cpu_clr;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_seen  = 0;

  always #5 clk = ~clk;

  program_loader dut (
    .clk      (clk),
    .clr      (clr),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .start    (start),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_we   (ram_we),
    .cpu_clr  (cpu_clr),
    .done     (done),
    .err      (err)
  );

  // Every cycle with the strobe high counts as one RAM write.
  always @(negedge clk) if (ram_we === 1'b1) wr_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Idle cycles with in_valid low; optional random start pulses must be ignored.
  task automatic stall(input int n, input bit rand_start);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      start    = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("stall_we", ram_we, 1'b0);
    end
  endtask

  // Present one byte, wait (bounded) for in_ready, then check the write port
  // in the cycle after the handshake. Called and returns at a falling edge.
  task automatic send_byte(input logic [7:0] b, input bit exp_we,
                           input logic [3:0] exp_addr, input string tag);
    int t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      check({tag, "_ready_timeout"}, in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = 8'($urandom);
    @(negedge clk);
    check({tag, "_we"}, ram_we, exp_we);
    if (exp_we) begin
      check({tag, "_addr"}, ram_addr, exp_addr);
      check({tag, "_data"}, ram_data, b);
    end
  endtask

  task automatic rearm();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("rearm_ready", in_ready, 1'b1);
    check("rearm_err", err, 1'b0);
    check("rearm_done", done, 1'b0);
    check("rearm_cpu_clr", cpu_clr, 1'b1);
  endtask

  // Full load transaction checked against the stream rules.
  task automatic run_stream(input logic [7:0] len_b, input byte_q_t data,
                            input logic [7:0] csum, input int smin, input int smax);
    int         n   = int'(len_b[4:0]);
    bit         bad = (n == 0) || (n > 16);
    int         w0  = wr_seen;
    logic [7:0] sum = 8'd0;
    bit         ok  = 1'b1;
    stall($urandom_range(smin, smax), 1'b1);
    send_byte(len_b, 1'b0, 4'd0, "len");
    if (bad) begin
      check("bad_err", err, 1'b1);
      check("bad_ready", in_ready, 1'b0);
      check("bad_cpu_clr", cpu_clr, 1'b1);
      check("bad_done", done, 1'b0);
      repeat (2) @(negedge clk);
      check("bad_err_hold", err, 1'b1);
      check("bad_cpu_clr_hold", cpu_clr, 1'b1);
    end else begin
      for (int i = 0; i < n; i++) begin
        stall($urandom_range(smin, smax), 1'b1);
        send_byte(data[i], 1'b1, 4'(i), "prog");
        sum = sum + data[i];
      end
`ifdef CHECKSUM_EN
      check("chk_ready", in_ready, 1'b1);
      check("chk_cpu_clr", cpu_clr, 1'b1);
      stall($urandom_range(smin, smax), 1'b1);
      send_byte(csum, 1'b0, 4'd0, "csum");
      ok = (csum == sum);
`endif
      check("fin_ready", in_ready, 1'b0);
      check("fin_cpu_clr_held", cpu_clr, 1'b1);
      check("fin_done_early", done, 1'b0);
      check("fin_err", err, !ok);
      @(negedge clk);
      check("post_cpu_clr", cpu_clr, !ok);
      check("post_done", done, ok);
      check("post_err", err, !ok);
      check("post_we", ram_we, 1'b0);
    end
    check("wcnt", wr_seen - w0, bad ? 0 : n);
    rearm();
  endtask

  function automatic logic [7:0] sum_of(input byte_q_t q);
    logic [7:0] s = 8'd0;
    foreach (q[i]) s = s + q[i];
    return s;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t q;
    int      w0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    start    = 1'b0;
    clr      = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("rst_cpu_clr", cpu_clr, 1'b1);
    check("rst_we", ram_we, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_addr", ram_addr, 4'd0);
    check("rst_data", ram_data, 8'd0);

    // Reference stream: three bytes, checksum 0x2D.
    q = '{8'h1E, 8'h2F, 8'hE0};
    run_stream(8'h03, q, 8'h2D, 0, 0);

    // Bad lengths, and upper length bits ignored.
    q = {};
    run_stream(8'h00, q, 8'h00, 0, 0);
    run_stream(8'h11, q, 8'h00, 0, 0);
    run_stream(8'hE0, q, 8'h00, 0, 0);
    q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    run_stream(8'hA5, q, sum_of(q), 0, 1);

    // Full 16-byte load with in_valid alternating every cycle.
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
    run_stream(8'h10, q, sum_of(q), 1, 1);

`ifdef CHECKSUM_EN
    q = '{8'h01, 8'h02};
    run_stream(8'h02, q, 8'h04, 0, 0);
`endif

    // clr mid-load, together with a handshake and a start pulse.
    send_byte(8'h04, 1'b0, 4'd0, "mid_len");
    send_byte(8'hA1, 1'b1, 4'd0, "mid_b0");
    send_byte(8'hB2, 1'b1, 4'd1, "mid_b1");
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    start    = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    in_valid = 1'b0;
    start    = 1'b0;
    @(negedge clk);
    check("midclr_ready", in_ready, 1'b1);
    check("midclr_we", ram_we, 1'b0);
    check("midclr_cpu_clr", cpu_clr, 1'b1);
    check("midclr_err", err, 1'b0);
    w0 = wr_seen;
    repeat (3) @(negedge clk);
    check("midclr_no_writes", wr_seen - w0, 0);
    check("midclr_idle", in_ready, 1'b1);
    q = '{8'hC3, 8'h3C, 8'h5A, 8'hA5};
    run_stream(8'h04, q, sum_of(q), 0, 2);

    // Randomized streams.
    for (int s = 0; s < 30; s++) begin
      logic [7:0] len_b;
      logic [7:0] cs;
      int         n;
      if ($urandom_range(0, 99) < 85) n = $urandom_range(1, 16);
      else if ($urandom_range(0, 1) == 0) n = 0;
      else n = $urandom_range(17, 31);
      len_b = {3'($urandom), 5'(n)};
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      cs = sum_of(q);
      if ($urandom_range(0, 9) >= 7) cs = cs ^ 8'($urandom_range(1, 255));
      run_stream(len_b, q, cs, 0, 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
